// File: rtl/if_stage.sv
// rtl/if_stage.sv - MiniMIPS32 fetch stage: PC select, imem drive, IF/ID register, stall hold buffer
// Optional fetch alignment exception under `IF_ADDR_ALIGN_EXC_EN.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] cp0_excaddr,
    input  logic [1:0]  jtsel,
    input  logic [31:0] addr1,
    input  logic [31:0] addr2,
    input  logic [31:0] addr3,
    input  logic        next_delay_i,
    input  logic [31:0] inst_i,
    output logic        ice,
    output logic [31:0] iaddr,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_in_delay_o,
    output logic        flush_im,
    output logic [4:0]  if_exccode_o
);

    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

    hold_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] hold_q, hold_d;
    logic        delay_q, delay_d;
    logic        bubble_q, bubble_d;
    logic [4:0]  exc_q, exc_d;
    logic        misaligned;
    logic        advance;

`ifdef IF_ADDR_ALIGN_EXC_EN
    assign misaligned = |pc_q[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = cp0_excaddr;
        end else if (!stall_if) begin
            case (jtsel)
                2'b01:   pc_d = addr3;
                2'b10:   pc_d = addr1;
                2'b11:   pc_d = addr2;
                default: pc_d = pc_q + 32'd4;
            endcase
        end
    end

    always_comb begin
        ice     = cpu_rst_n & ~stall_if & ~flush & ~misaligned;
        advance = ~stall_id | flush;

        id_pc_d  = id_pc_q;
        delay_d  = delay_q;
        bubble_d = bubble_q;
        exc_d    = exc_q;
        if (advance) begin
            id_pc_d  = pc_q;
            delay_d  = next_delay_i & ~flush;
            // A word that was never fetched reaches decode as a bubble.
            bubble_d = flush | ~ice;
            exc_d    = (misaligned && !flush) ? EXC_ADEL : EXC_NONE;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            RUN: begin
                if (stall_id && !flush) begin
                    hold_d  = inst_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (advance) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pc_q     <= PC_RESET;
            id_pc_q  <= PC_RESET;
            hold_q   <= 32'h0;
            delay_q  <= 1'b0;
            bubble_q <= 1'b1;
            exc_q    <= EXC_NONE;
            state_q  <= RUN;
        end else begin
            pc_q     <= pc_d;
            id_pc_q  <= id_pc_d;
            hold_q   <= hold_d;
            delay_q  <= delay_d;
            bubble_q <= bubble_d;
            exc_q    <= exc_d;
            state_q  <= state_d;
        end
    end

    // Memory data is meaningless while reset is held, so decode sees zero then.
    assign id_inst_o     = (state_q == HOLD) ? hold_q : (cpu_rst_n ? inst_i : 32'h0);
    assign iaddr         = pc_q;
    assign id_pc_o       = id_pc_q;
    assign id_in_delay_o = delay_q;
    assign flush_im      = bubble_q;
    assign if_exccode_o  = exc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;
    localparam logic [31:0] EXC_NONE = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_if = 1'b0, stall_id = 1'b0, flush = 1'b0, next_delay_i = 1'b0;
    logic [31:0] cp0_excaddr = '0, addr1 = '0, addr2 = '0, addr3 = '0;
    logic [1:0]  jtsel = 2'b00;
    logic [31:0] inst_i;
    logic        ice, id_in_delay_o, flush_im;
    logic [31:0] iaddr, id_pc_o, id_inst_o;
    logic [4:0]  if_exccode_o;
    logic [31:0] mem_q = GARBAGE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory returns the fetched address as data; undefined cycles return a marker.
    always @(posedge clk) mem_q <= ice ? iaddr : GARBAGE;
    assign inst_i = mem_q;

    if_stage dut (
        .cpu_clk_50M  (clk),
        .cpu_rst_n    (rst_n),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush        (flush),
        .cp0_excaddr  (cp0_excaddr),
        .jtsel        (jtsel),
        .addr1        (addr1),
        .addr2        (addr2),
        .addr3        (addr3),
        .next_delay_i (next_delay_i),
        .inst_i       (inst_i),
        .ice          (ice),
        .iaddr        (iaddr),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_in_delay_o(id_in_delay_o),
        .flush_im     (flush_im),
        .if_exccode_o (if_exccode_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic bubble);
        check({tag, ".id_pc"}, id_pc_o, pc);
        check({tag, ".id_inst"}, id_inst_o, inst);
        check({tag, ".flush_im"}, {31'b0, flush_im}, {31'b0, bubble});
    endtask

    initial begin
        step();
        step();
        check("rst.ice", {31'b0, ice}, 32'd0);
        check("rst.iaddr", iaddr, 32'h0);
        check_id("rst", 32'h0, 32'h0, 1'b1);
        check("rst.delay", {31'b0, id_in_delay_o}, 32'd0);
        check("rst.exc", {27'b0, if_exccode_o}, EXC_NONE);

        rst_n = 1'b1;
        #1;
        check("c0.ice", {31'b0, ice}, 32'd1);
        check("c0.iaddr", iaddr, 32'h0);
        check("c0.flush_im", {31'b0, flush_im}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("run.iaddr", iaddr, 32'(4 * k));
            check_id("run", 32'(4 * (k - 1)), 32'(4 * (k - 1)), 1'b0);
        end

        // Stall both stages for three cycles at PC=0x10.
        stall_if = 1'b1; stall_id = 1'b1;
        #1;
        check("stall.ice", {31'b0, ice}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall.iaddr", iaddr, 32'h10);
            check_id("stall", 32'h0C, 32'h0C, 1'b0);
        end
        step();
        stall_if = 1'b0; stall_id = 1'b0;
        #1;
        check("rel.iaddr", iaddr, 32'h10);
        check_id("rel", 32'h0C, 32'h0C, 1'b0);
        step();
        check("rel1.iaddr", iaddr, 32'h14);
        check_id("rel1", 32'h10, 32'h10, 1'b0);
        step();
        check("rel2.iaddr", iaddr, 32'h18);
        check_id("rel2", 32'h14, 32'h14, 1'b0);

        // Jump via addr1 with delay slot.
        jtsel = 2'b10; addr1 = 32'h0000_0100; next_delay_i = 1'b1;
        step();
        jtsel = 2'b00; next_delay_i = 1'b0;
        check("jmp.iaddr", iaddr, 32'h100);
        check_id("jmp", 32'h18, 32'h18, 1'b0);
        check("jmp.delay", {31'b0, id_in_delay_o}, 32'd1);
        step();
        check("jmp1.iaddr", iaddr, 32'h104);
        check_id("jmp1", 32'h100, 32'h100, 1'b0);
        check("jmp1.delay", {31'b0, id_in_delay_o}, 32'd0);

        // Flush arriving during a stall.
        stall_if = 1'b1; stall_id = 1'b1;
        step();
        flush = 1'b1; cp0_excaddr = 32'h380; next_delay_i = 1'b1;
        #1;
        check("fl.ice", {31'b0, ice}, 32'd0);
        step();
        flush = 1'b0; stall_if = 1'b0; stall_id = 1'b0; next_delay_i = 1'b0;
        check("fl.iaddr", iaddr, 32'h380);
        check_id("fl", 32'h104, GARBAGE, 1'b1);
        check("fl.delay", {31'b0, id_in_delay_o}, 32'd0);
        step();
        check("fl1.iaddr", iaddr, 32'h384);
        check_id("fl1", 32'h380, 32'h380, 1'b0);

        // Redirect during stall_if must not move the PC.
        stall_if = 1'b1; stall_id = 1'b1; jtsel = 2'b01; addr3 = 32'h500;
        step();
        stall_if = 1'b0; stall_id = 1'b0; addr3 = 32'hFFFF_FFFC;
        check("sj.iaddr", iaddr, 32'h384);
        step();
        jtsel = 2'b00;
        check("sj1.iaddr", iaddr, 32'hFFFF_FFFC);
        check_id("sj1", 32'h384, 32'h384, 1'b0);
        step();
        check("wrap.iaddr", iaddr, 32'h0);
        check_id("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        check("wrap.exc", {27'b0, if_exccode_o}, EXC_NONE);

        // Asynchronous reset mid-stream while holding.
        stall_id = 1'b1;
        step();
        rst_n = 1'b0; stall_id = 1'b0;
        #1;
        check("arst.iaddr", iaddr, 32'h0);
        check("arst.ice", {31'b0, ice}, 32'd0);
        check_id("arst", 32'h0, 32'h0, 1'b1);
        step();
        rst_n = 1'b1;
        #1;
        check("arst0.iaddr", iaddr, 32'h0);
        step();
        check_id("arst1", 32'h0, 32'h0, 1'b0);
        check("arst1.iaddr", iaddr, 32'h4);

`ifdef IF_ADDR_ALIGN_EXC_EN
        jtsel = 2'b01; addr3 = 32'h102;
        step();
        jtsel = 2'b00;
        check("al.iaddr", iaddr, 32'h102);
        check("al.ice", {31'b0, ice}, 32'd0);
        step();
        check("al1.id_pc", id_pc_o, 32'h102);
        check("al1.exc", {27'b0, if_exccode_o}, 32'h04);
        check("al1.flush_im", {31'b0, flush_im}, 32'd1);
        check("al1.iaddr", iaddr, 32'h106);
`else
        jtsel = 2'b01; addr3 = 32'h102;
        step();
        jtsel = 2'b00;
        check("na.ice", {31'b0, ice}, 32'd1);
        step();
        check("na1.id_pc", id_pc_o, 32'h102);
        check("na1.exc", {27'b0, if_exccode_o}, EXC_NONE);
        check("na1.flush_im", {31'b0, flush_im}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
